// File: rtl/key_cmd_scheduler_if.sv
// Command handshake between the key scheduler and the piece-movement controller.
// The producer drives a command code with a valid flag; the consumer answers with ready.
interface key_cmd_scheduler_if;
   logic       cmd_valid;
   logic [2:0] cmd_code;
   logic       cmd_ready;

   modport master (output cmd_valid, output cmd_code, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/key_cmd_scheduler.sv
// Key command scheduler: turns debounced button levels into a serialized command stream.
// Press edges and auto-repeat (for masked-in movement keys) raise a per-key pending bit;
// a fixed-priority arbiter issues one pending key at a time over a valid/ready handshake.
module key_cmd_scheduler #(
   parameter int         TICK_DIV     = 100000,
   parameter int         REPEAT_DELAY = 20,
   parameter int         REPEAT_RATE  = 5,
   parameter logic [4:0] REPEAT_MASK  = 5'b00111
) (
   input  logic                        clk,
   input  logic                        clr,
   input  logic [4:0]                  key_lvl,
   input  logic                        enable,
   key_cmd_scheduler_if.master         cmd,
   output logic                        overrun
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   typedef enum logic {IDLE, HOLD} state_t;

   logic [PW-1:0] pcnt;
   logic          tick;
   logic [4:0]    prev;
   logic [4:0]    press;
   logic [4:0]    rpt;
   logic [4:0]    ev;
   logic [4:0]    pending;
   logic [4:0]    grant;
   logic [2:0]    win_code;
   state_t        state;

   assign tick  = (pcnt == PW'(TICK_DIV - 1));
   assign press = key_lvl & ~prev;
   assign ev    = press | rpt;

   // Repeat timebase: free-running prescaler, one tick per TICK_DIV cycles.
   always_ff @(posedge clk or posedge clr) begin
      if (clr)       pcnt <= '0;
      else if (tick) pcnt <= '0;
      else           pcnt <= pcnt + 1'b1;
   end

   // Previous key levels for rising-edge detection; reset to 0 so a held key presses once.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) prev <= '0;
      else     prev <= key_lvl;
   end

   // Per-key auto-repeat counters; keys outside the mask never repeat.
   for (genvar i = 0; i < 5; i++) begin : g_rep
      if (REPEAT_MASK[i]) begin : g_on
         logic [7:0] cnt;

         assign rpt[i] = key_lvl[i] & ~press[i] & tick & (cnt == 8'd1);

         // A press reloads the delay and wins over a tick in the same cycle.
         always_ff @(posedge clk or posedge clr) begin
            if (clr)                        cnt <= '0;
            else if (press[i])              cnt <= 8'(REPEAT_DELAY);
            else if (!key_lvl[i])           cnt <= '0;
            else if (tick && cnt == 8'd1)   cnt <= 8'(REPEAT_RATE);
            else if (tick && cnt > 8'd1)    cnt <= cnt - 8'd1;
         end
      end else begin : g_off
         assign rpt[i] = 1'b0;
      end
   end

   // Fixed-priority pick among pending keys: drop > rotate > down > left > right.
   always_comb begin
      grant    = '0;
      win_code = '0;
      if (state == IDLE && enable) begin
         if (pending[4])      begin grant[4] = 1'b1; win_code = 3'd5; end
         else if (pending[3]) begin grant[3] = 1'b1; win_code = 3'd4; end
         else if (pending[2]) begin grant[2] = 1'b1; win_code = 3'd3; end
         else if (pending[0]) begin grant[0] = 1'b1; win_code = 3'd1; end
         else if (pending[1]) begin grant[1] = 1'b1; win_code = 3'd2; end
      end
   end

   // Pending bits coalesce events; a new event beats a same-cycle grant clear.
   always_ff @(posedge clk or posedge clr) begin
      if (clr)          pending <= '0;
      else if (!enable) pending <= '0;
      else              pending <= (pending & ~grant) | ev;
   end

   // Overrun flags an event lost to an already-pending, non-granted key.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) overrun <= 1'b0;
      else     overrun <= enable & (|(ev & pending & ~grant));
   end

   // Issue FSM: IDLE launches the arbiter winner, HOLD keeps it stable until accepted.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state         <= IDLE;
         cmd.cmd_valid <= 1'b0;
         cmd.cmd_code  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|grant) begin
                  cmd.cmd_valid <= 1'b1;
                  cmd.cmd_code  <= win_code;
                  state         <= HOLD;
               end else begin
                  cmd.cmd_valid <= 1'b0;
                  cmd.cmd_code  <= '0;
               end
            end
            HOLD: begin
               if (cmd.cmd_ready) begin
                  cmd.cmd_valid <= 1'b0;
                  cmd.cmd_code  <= '0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Scoreboard bench for key_cmd_scheduler: directed key sequences push expected codes,
// a negedge monitor pops and compares on every accepted command.
module tb_key_cmd_scheduler;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [4:0] key_lvl = '0;
   logic       enable = 1'b1;
   logic       overrun;

   key_cmd_scheduler_if bus();

   key_cmd_scheduler #(
      .TICK_DIV(4), .REPEAT_DELAY(3), .REPEAT_RATE(2), .REPEAT_MASK(5'b00111)
   ) dut (
      .clk(clk), .clr(clr), .key_lvl(key_lvl), .enable(enable), .cmd(bus), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int       n_chk = 0;
   int       n_fail = 0;
   int       ovr_cnt = 0;
   int       cyc = 0;
   logic [2:0] sb[$];

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // advance n rising edges, then settle 2 time units past the edge
   task automatic step(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_empty(int budget);
      int b = budget;
      while (sb.size() != 0 && b > 0) begin
         @(posedge clk);
         b--;
      end
      #2;
      chk("sb_drained", sb.size(), 0);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: compares each accepted command against the scoreboard head.
   initial begin : monitor
      logic last_acc = 1'b0;
      forever begin
         @(negedge clk);
         if (clr) begin
            last_acc = 1'b0;
         end else begin
            if (last_acc) chk("bubble_after_accept", int'(bus.cmd_valid), 0);
            if (overrun) ovr_cnt++;
            if (bus.cmd_valid && bus.cmd_ready) begin
               if (sb.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_cmd: got code %0d expected none (t=%0t)", bus.cmd_code, $time);
               end else begin
                  chk("cmd_code", int'(bus.cmd_code), int'(sb.pop_front()));
               end
               last_acc = 1'b1;
            end else begin
               last_acc = 1'b0;
            end
         end
      end
   end

   initial begin : stim
      int base;
      int t0;
      bus.cmd_ready = 1'b1;

      // reset state
      step(3);
      @(negedge clk);
      chk("rst_valid", int'(bus.cmd_valid), 0);
      chk("rst_code", int'(bus.cmd_code), 0);
      chk("rst_overrun", int'(overrun), 0);
      step(1);
      clr = 1'b0;
      step(2);

      // rotate held 40 cycles: one command, valid 2 edges after rise, 1 cycle wide
      sb.push_back(3'd4);
      key_lvl = 5'b01000;
      step(1);
      chk("rot_not_yet", int'(bus.cmd_valid), 0);
      step(1);
      @(negedge clk);
      chk("rot_valid", int'(bus.cmd_valid), 1);
      chk("rot_code", int'(bus.cmd_code), 4);
      step(1);
      @(negedge clk);
      chk("rot_one_cycle", int'(bus.cmd_valid), 0);
      step(38);
      key_lvl = '0;
      step(4);
      chk("rot_only_one", sb.size(), 0);

      // left held for 9 ticks after press: press + repeats at ticks 3,5,7,9
      repeat (5) sb.push_back(3'd1);
      key_lvl = 5'b00001;
      step(37);
      key_lvl = '0;
      wait_empty(20);
      step(4);

      // left released before the first repeat: exactly one command
      sb.push_back(3'd1);
      key_lvl = 5'b00001;
      step(8);
      key_lvl = '0;
      wait_empty(20);
      step(10);

      // simultaneous left/down/drop: priority order 5,3,1, no overrun
      base = ovr_cnt;
      sb.push_back(3'd5);
      sb.push_back(3'd3);
      sb.push_back(3'd1);
      key_lvl = 5'b10101;
      step(6);
      key_lvl = '0;
      wait_empty(20);
      step(4);
      chk("prio_no_overrun", ovr_cnt - base, 0);

      // drop stalled with ready low; two re-presses during HOLD
      base = ovr_cnt;
      bus.cmd_ready = 1'b0;
      sb.push_back(3'd5);
      sb.push_back(3'd5);
      key_lvl = 5'b10000;
      step(2);
      @(negedge clk);
      chk("hold_valid", int'(bus.cmd_valid), 1);
      chk("hold_code", int'(bus.cmd_code), 5);
      key_lvl = '0;
      step(1);
      key_lvl = 5'b10000;
      step(1);
      key_lvl = '0;
      step(1);
      chk("first_repress_no_ovr", ovr_cnt - base, 0);
      key_lvl = 5'b10000;
      step(2);
      chk("second_repress_ovr", ovr_cnt - base, 1);
      chk("hold_code_stable", int'(bus.cmd_code), 5);
      bus.cmd_ready = 1'b1;
      wait_empty(20);
      key_lvl = '0;
      step(6);
      chk("ovr_single_pulse", ovr_cnt - base, 1);

      // down pressed while disabled: nothing until the first repeat tick after enable
      enable = 1'b0;
      key_lvl = 5'b00100;
      step(2);
      enable = 1'b1;
      t0 = cyc;
      sb.push_back(3'd3);
      wait_empty(40);
      chk("repeat_after_enable_min", int'((cyc - t0) >= 9), 1);
      chk("repeat_after_enable_max", int'((cyc - t0) <= 14), 1);
      key_lvl = '0;
      step(6);

      // reset mid-HOLD drops the command; right held through release presses again
      bus.cmd_ready = 1'b0;
      sb.push_back(3'd2);
      key_lvl = 5'b00010;
      step(2);
      @(negedge clk);
      chk("pre_rst_code", int'(bus.cmd_code), 2);
      #1;
      clr = 1'b1;
      #1;
      chk("async_rst_valid", int'(bus.cmd_valid), 0);
      chk("async_rst_code", int'(bus.cmd_code), 0);
      sb.delete();
      step(2);
      clr = 1'b0;
      bus.cmd_ready = 1'b1;
      sb.push_back(3'd2);
      step(1);
      chk("post_rst_not_yet", int'(bus.cmd_valid), 0);
      step(1);
      @(negedge clk);
      chk("post_rst_valid", int'(bus.cmd_valid), 1);
      chk("post_rst_code", int'(bus.cmd_code), 2);
      step(1);
      key_lvl = '0;
      wait_empty(10);
      step(10);

      chk("final_sb_empty", sb.size(), 0);
      chk("final_idle", int'(bus.cmd_valid), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // global time limit so the bench always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation ran past time limit");
      $fatal(1);
   end

endmodule
